wb_write_arbiter: RTL and testbench

- Writer end of the integer register array: drives its single write port (RegWEn/AddrD/DataD) each cycle.
- Merges two result sources: the single-cycle ALU path, which has fixed priority and no backpressure, and the long-latency LSU path, which is buffered in a small FIFO.
- Keeps a pending-write scoreboard per architectural register so decode can stall on in-flight LSU destinations.

---
 rtl/core_pkg.sv | 15 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/wb_write_arbiter.sv | 108 ++++++++++
 tb/tb_wb_write_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core types and constants for the register write-back path.
package core_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   // One buffered register write: destination and value.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO without bypass; the head is visible on data_o while non-empty.
module sync_fifo #(
   parameter type         T     = logic,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  T                           data_i,
   input  logic                       pop_i,
   output T                           data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   T                mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q;
   logic [AW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Storage array; contents are meaningless once the pointers are reset.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU first, buffered LSU results otherwise,
// plus a per-register scoreboard of outstanding LSU writes.
module wb_write_arbiter
   import core_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        alu_valid,
   input  logic [REG_ADDR_W-1:0]       alu_rd,
   input  logic [XLEN-1:0]             alu_data,
   input  logic                        lsu_valid,
   output logic                        lsu_ready,
   input  logic [REG_ADDR_W-1:0]       lsu_rd,
   input  logic [XLEN-1:0]             lsu_data,
   input  logic                        issue_valid,
   input  logic [REG_ADDR_W-1:0]       issue_rd,
   output logic                        RegWEn,
   output logic [REG_ADDR_W-1:0]       AddrD,
   output logic [XLEN-1:0]             DataD,
   output logic [31:0]                 pending,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   wb_entry_t               push_entry;
   wb_entry_t               head_entry;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    alu_sel;
   logic                    ready_en_q;

   logic                    reg_wen_q,  reg_wen_d;
   logic [REG_ADDR_W-1:0]   addr_q,     addr_d;
   logic [XLEN-1:0]         data_q,     data_d;
   logic [31:0]             pending_q,  pending_d;

   // ready_en_q keeps lsu_ready low during reset without a path from lsu_valid.
   assign lsu_ready  = ready_en_q && !fifo_full;
   assign alu_sel    = alu_valid && (alu_rd != REG_ZERO);
   assign fifo_push  = lsu_valid && lsu_ready && (lsu_rd != REG_ZERO);
   assign fifo_pop   = !alu_sel && !fifo_empty;

   assign push_entry.rd   = lsu_rd;
   assign push_entry.data = lsu_data;

   sync_fifo #(
      .T     (wb_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_lsu_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .data_i  (push_entry),
      .pop_i   (fifo_pop),
      .data_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Select the write source and update the scoreboard; issue set beats pop clear.
   always_comb begin
      reg_wen_d = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      pending_d = pending_q;
      if (alu_sel) begin
         reg_wen_d = 1'b1;
         addr_d    = alu_rd;
         data_d    = alu_data;
      end else if (fifo_pop) begin
         reg_wen_d = 1'b1;
         addr_d    = head_entry.rd;
         data_d    = head_entry.data;
         pending_d[head_entry.rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != REG_ZERO)) begin
         pending_d[issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // Registered write port and scoreboard.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wen_q  <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         pending_q  <= '0;
         ready_en_q <= 1'b0;
      end else begin
         reg_wen_q  <= reg_wen_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         pending_q  <= pending_d;
         ready_en_q <= 1'b1;
      end
   end

   assign RegWEn  = reg_wen_q;
   assign AddrD   = addr_q;
   assign DataD   = data_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed self-checking bench for wb_write_arbiter.
module tb_wb_write_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        RegWEn;
   logic [4:0]  AddrD;
   logic [31:0] DataD;
   logic [31:0] pending;
   logic [2:0]  fifo_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_write_arbiter #(.FIFO_DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .RegWEn      (RegWEn),
      .AddrD       (AddrD),
      .DataD       (DataD),
      .pending     (pending),
      .fifo_count  (fifo_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_valid   = 1'b0; alu_rd   = 5'd0; alu_data = 32'h0;
      lsu_valid   = 1'b0; lsu_rd   = 5'd0; lsu_data = 32'h0;
      issue_valid = 1'b0; issue_rd = 5'd0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      #2;
      check("rst_wen",     32'(RegWEn),     32'h0);
      check("rst_addr",    32'(AddrD),      32'h0);
      check("rst_data",    DataD,           32'h0);
      check("rst_pending", pending,         32'h0);
      check("rst_count",   32'(fifo_count), 32'h0);
      check("rst_ready",   32'(lsu_ready),  32'h0);
      #10 rst_n = 1'b1;
      step();
      check("post_rst_wen",   32'(RegWEn),    32'h0);
      check("post_rst_ready", 32'(lsu_ready), 32'h1);

      // ALU single write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      step();
      check("alu_wen",  32'(RegWEn), 32'h1);
      check("alu_addr", 32'(AddrD),  32'h5);
      check("alu_data", DataD,       32'hDEADBEEF);
      idle();
      step();
      check("alu_wen_off",   32'(RegWEn), 32'h0);
      check("alu_addr_hold", 32'(AddrD),  32'h5);
      check("alu_data_hold", DataD,       32'hDEADBEEF);

      // Issue rd7, then LSU result to rd7
      issue_valid = 1'b1; issue_rd = 5'd7;
      step();
      check("pend7_set", pending, 32'h0000_0080);
      idle();
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h11;
      step();
      check("lsu_hs_wen",   32'(RegWEn),     32'h0);
      check("lsu_hs_count", 32'(fifo_count), 32'h1);
      check("lsu_hs_pend",  pending,         32'h0000_0080);
      idle();
      step();
      check("lsu_wr_wen",  32'(RegWEn), 32'h1);
      check("lsu_wr_addr", 32'(AddrD),  32'h7);
      check("lsu_wr_data", DataD,       32'h11);
      check("lsu_wr_pend", pending,     32'h0);
      check("lsu_wr_cnt",  32'(fifo_count), 32'h0);
      step();
      check("lsu_wr_off", 32'(RegWEn), 32'h0);

      // ALU busy 6 cycles while LSU offers 5 results (rd 11..15)
      for (int i = 0; i < 6; i++) begin
         int k;
         k = (i < 4) ? i : 4;
         alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_data = 32'hA000 + 32'(i);
         lsu_valid = 1'b1; lsu_rd = 5'(11 + k); lsu_data = 32'h100 + 32'(k);
         step();
         check("busy_wen",   32'(RegWEn),     32'h1);
         check("busy_addr",  32'(AddrD),      32'(10 + i));
         check("busy_data",  DataD,           32'hA000 + 32'(i));
         check("busy_count", 32'(fifo_count), (i < 4) ? 32'(i + 1) : 32'h4);
         check("busy_ready", 32'(lsu_ready),  (i < 3) ? 32'h1 : 32'h0);
      end
      idle();
      for (int j = 0; j < 4; j++) begin
         step();
         check("drain_wen",   32'(RegWEn),     32'h1);
         check("drain_addr",  32'(AddrD),      32'(11 + j));
         check("drain_data",  DataD,           32'h100 + 32'(j));
         check("drain_count", 32'(fifo_count), 32'(3 - j));
         check("drain_ready", 32'(lsu_ready),  32'h1);
      end
      step();
      check("drain_done_wen", 32'(RegWEn), 32'h0);

      // LSU rd0 is dropped
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hFF;
      step();
      check("rd0_count", 32'(fifo_count), 32'h0);
      idle();
      step();
      check("rd0_wen", 32'(RegWEn), 32'h0);

      // ALU rd0 counts as idle: queued head drains
      lsu_valid = 1'b1; lsu_rd = 5'd20; lsu_data = 32'h55;
      step();
      check("q20_count", 32'(fifo_count), 32'h1);
      idle();
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h999;
      step();
      check("alu0_wen",   32'(RegWEn),     32'h1);
      check("alu0_addr",  32'(AddrD),      32'd20);
      check("alu0_data",  DataD,           32'h55);
      check("alu0_count", 32'(fifo_count), 32'h0);
      idle();

      // Same-cycle set and clear of rd9: set wins
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      check("pend9_set", pending, 32'h0000_0200);
      idle();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h77;
      step();
      check("q9_count", 32'(fifo_count), 32'h1);
      idle();
      issue_valid = 1'b1; issue_rd = 5'd9;
      step();
      check("race9_wen",  32'(RegWEn), 32'h1);
      check("race9_addr", 32'(AddrD),  32'd9);
      check("race9_pend", pending,     32'h0000_0200);
      idle();

      // Queue rd 3,4,6 behind a busy ALU, then reset mid-cycle
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
      issue_valid = 1'b1; lsu_valid = 1'b1;
      issue_rd = 5'd3; lsu_rd = 5'd3; lsu_data = 32'h33;
      step();
      issue_rd = 5'd4; lsu_rd = 5'd4; lsu_data = 32'h44;
      step();
      issue_rd = 5'd6; lsu_rd = 5'd6; lsu_data = 32'h66;
      step();
      check("pre_rst_count", 32'(fifo_count), 32'h3);
      check("pre_rst_pend",  pending,         32'h0000_0258);
      check("pre_rst_wen",   32'(RegWEn),     32'h1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_wen",   32'(RegWEn),     32'h0);
      check("mid_rst_pend",  pending,         32'h0);
      check("mid_rst_count", 32'(fifo_count), 32'h0);
      check("mid_rst_ready", 32'(lsu_ready),  32'h0);
      idle();
      step();
      #2 rst_n = 1'b1;
      step();
      check("after_rst_wen",   32'(RegWEn),     32'h0);
      check("after_rst_count", 32'(fifo_count), 32'h0);
      step();
      check("after_rst_wen2",  32'(RegWEn),     32'h0);
      check("after_rst_ready", 32'(lsu_ready),  32'h1);
      check("after_rst_pend",  pending,         32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
